// File: rtl/zoom_hdmi_pkg.sv
// rtl/zoom_hdmi_pkg.sv - shared types and raster sizing helpers for the zoom-to-HDMI FIFO reader
package zoom_hdmi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        DROP  = 2'd3
    } state_t;

    // Per-cycle video attributes carried alongside the FIFO read latency.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic tag;
        logic fs;
    } vid_tag_t;

    localparam int DATA_W_DEF = 24;

    function automatic int raster_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int cnt_width(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/zoom_hdmi_timing_gen.sv
// rtl/zoom_hdmi_timing_gen.sv - h/v raster counters with region decode and frame-end flag
module zoom_hdmi_timing_gen
    import zoom_hdmi_pkg::*;
#(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic hold,
    output logic active,
    output logic hsync,
    output logic vsync,
    output logic first_px,
    output logic frame_end
);

    localparam int H_TOTAL = raster_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = raster_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int H_W     = cnt_width(H_TOTAL);
    localparam int V_W     = cnt_width(V_TOTAL);

    localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_ACT  = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] HS_BEG = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] HS_END = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] V_ACT  = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] VS_BEG = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] VS_END = V_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [H_W-1:0] h_cnt;
    logic [V_W-1:0] v_cnt;
    logic           h_last;
    logic           v_last;

    assign h_last = (h_cnt == H_LAST);
    assign v_last = (v_cnt == V_LAST);

    always_ff @(posedge clk) begin
        if (rst || hold) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    assign active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hsync     = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    assign vsync     = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    assign first_px  = (h_cnt == '0) && (v_cnt == '0);
    assign frame_end = h_last && v_last;

endmodule

// File: rtl/zoom_hdmi_fifo_reader.sv
// rtl/zoom_hdmi_fifo_reader.sv - HDMI-side pixel FIFO reader; optional ZOOM_HDMI_UNDERFLOW_CNT_EN adds underflow_cnt
module zoom_hdmi_fifo_reader
    import zoom_hdmi_pkg::*;
#(
    parameter int                DATA_W     = DATA_W_DEF,
    parameter int                H_ACTIVE   = 1280,
    parameter int                H_FP       = 110,
    parameter int                H_SYNC     = 40,
    parameter int                H_BP       = 220,
    parameter int                V_ACTIVE   = 720,
    parameter int                V_FP       = 5,
    parameter int                V_SYNC     = 5,
    parameter int                V_BP       = 20,
    parameter int                RD_LATENCY = 2,
    parameter logic              HS_POL     = 1'b1,
    parameter logic              VS_POL     = 1'b1,
    parameter logic [DATA_W-1:0] FILL_COLOR = '0
) (
    input  logic              rd_clk,
    input  logic              rd_rst,
    input  logic              enable,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    input  logic              fifo_rd_empty,
    input  logic              fifo_almost_empty,
    output logic              vid_hs,
    output logic              vid_vs,
    output logic              vid_de,
    output logic [DATA_W-1:0] vid_data,
    output logic              frame_start,
    output logic              underflow
`ifdef ZOOM_HDMI_UNDERFLOW_CNT_EN
    ,
    output logic [15:0]       underflow_cnt
`endif
);

    state_t   state;
    state_t   state_nxt;
    logic     active;
    logic     hsync;
    logic     vsync;
    logic     first_px;
    logic     frame_end;
    logic     running;
    logic     pop;
    logic     uf_now;
    vid_tag_t cur;
    vid_tag_t tail;
    vid_tag_t pipe [RD_LATENCY];

    zoom_hdmi_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk       (rd_clk),
        .rst       (rd_rst),
        .hold      (state == IDLE),
        .active    (active),
        .hsync     (hsync),
        .vsync     (vsync),
        .first_px  (first_px),
        .frame_end (frame_end)
    );

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        uf_now    = 1'b0;
        case (state)
            IDLE: begin
                if (enable) state_nxt = PRIME;
            end
            PRIME: begin
                if (frame_end) begin
                    if (!enable)                state_nxt = IDLE;
                    else if (!fifo_almost_empty) state_nxt = RUN;
                end
            end
            RUN: begin
                pop    = active && !fifo_rd_empty;
                uf_now = active && fifo_rd_empty;
                if (uf_now)                   state_nxt = DROP;
                else if (frame_end && !enable) state_nxt = IDLE;
            end
            DROP: begin
                if (frame_end) state_nxt = enable ? PRIME : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign fifo_rd_en = pop;
    assign running    = (state != IDLE);

    always_comb begin
        cur     = '0;
        cur.hs  = running && hsync;
        cur.vs  = running && vsync;
        cur.de  = running && active;
        cur.tag = pop;
        cur.fs  = pop && first_px;
    end

    assign tail = pipe[RD_LATENCY-1];

    // The tag stage that leaves the pipe lines up with the word the FIFO returns this cycle.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            for (int i = 0; i < RD_LATENCY; i++) pipe[i] <= '0;
            vid_hs      <= ~HS_POL;
            vid_vs      <= ~VS_POL;
            vid_de      <= 1'b0;
            vid_data    <= '0;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            pipe[0] <= cur;
            for (int i = 1; i < RD_LATENCY; i++) pipe[i] <= pipe[i-1];
            vid_hs      <= tail.hs ? HS_POL : ~HS_POL;
            vid_vs      <= tail.vs ? VS_POL : ~VS_POL;
            vid_de      <= tail.de;
            vid_data    <= tail.de ? (tail.tag ? fifo_rd_data : FILL_COLOR) : '0;
            frame_start <= tail.fs;
            underflow   <= uf_now;
        end
    end

`ifdef ZOOM_HDMI_UNDERFLOW_CNT_EN
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            underflow_cnt <= '0;
        end else if (uf_now && (underflow_cnt != 16'hFFFF)) begin
            underflow_cnt <= underflow_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_zoom_hdmi_fifo_reader.sv
// tb/tb_zoom_hdmi_fifo_reader.sv - randomized self-checking bench for zoom_hdmi_fifo_reader on a small raster
module tb_zoom_hdmi_fifo_reader;

    localparam int HT  = 14;
    localparam int VT  = 7;
    localparam int FT  = HT * VT;
    localparam int LAT = 2;
    localparam int M_IDLE  = 0;
    localparam int M_PRIME = 1;
    localparam int M_RUN   = 2;

    logic        rd_clk = 1'b0;
    logic        rd_rst = 1'b1;
    logic        enable = 1'b0;
    logic        fifo_rd_en;
    logic [23:0] fifo_rd_data = '0;
    logic        fifo_rd_empty;
    logic        fifo_almost_empty;
    logic        vid_hs, vid_vs, vid_de, frame_start, underflow;
    logic [23:0] vid_data;
`ifdef ZOOM_HDMI_UNDERFLOW_CNT_EN
    logic [15:0] underflow_cnt;
`endif

    logic [23:0] mem [256];
    logic [7:0]  rptr = '0;
    logic [7:0]  wptr = '0;
    logic [23:0] d1 = '0;
    logic        force_empty = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          uf_total = 0;
    int          fmode[$];

    always #5 rd_clk = ~rd_clk;

    zoom_hdmi_fifo_reader #(
        .DATA_W(24), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .RD_LATENCY(LAT),
        .HS_POL(1'b1), .VS_POL(1'b1), .FILL_COLOR(24'h000000)
    ) dut (
        .rd_clk            (rd_clk),
        .rd_rst            (rd_rst),
        .enable            (enable),
        .fifo_rd_en        (fifo_rd_en),
        .fifo_rd_data      (fifo_rd_data),
        .fifo_rd_empty     (fifo_rd_empty),
        .fifo_almost_empty (fifo_almost_empty),
        .vid_hs            (vid_hs),
        .vid_vs            (vid_vs),
        .vid_de            (vid_de),
        .vid_data          (vid_data),
        .frame_start       (frame_start),
        .underflow         (underflow)
`ifdef ZOOM_HDMI_UNDERFLOW_CNT_EN
        ,
        .underflow_cnt     (underflow_cnt)
`endif
    );

    // FIFO with a registered output: data for a pop is visible two edges later.
    assign fifo_rd_empty     = (rptr == wptr) || force_empty;
    assign fifo_almost_empty = (8'(wptr - rptr) <= 8'd4);

    always @(posedge rd_clk) begin
        if (fifo_rd_en && !fifo_rd_empty) begin
            d1   <= mem[rptr];
            rptr <= rptr + 8'd1;
        end
        fifo_rd_data <= d1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit pos_active(input int p);
        int r;
        r = p % FT;
        return ((r % HT) < 8) && ((r / HT) < 4);
    endfunction

    function automatic bit pos_hs(input int p);
        int h;
        h = (p % FT) % HT;
        return (h >= 10) && (h < 12);
    endfunction

    function automatic bit pos_vs(input int p);
        return ((p % FT) / HT) == 5;
    endfunction

    function automatic int mode_of(input int p);
        int f;
        f = p / FT;
        return (f < fmode.size()) ? fmode[f] : M_IDLE;
    endfunction

    task automatic apply_reset();
        rd_rst      = 1'b1;
        enable      = 1'b0;
        force_empty = 1'b0;
        repeat (2) @(negedge rd_clk);
        #1;
        check("reset_video", {4'h0, vid_hs, vid_vs, vid_de, frame_start, vid_data}, 32'h0);
        check("reset_ctl", {30'h0, fifo_rd_en, underflow}, 32'h0);
        rd_rst   = 1'b0;
        uf_total = 0;
`ifdef ZOOM_HDMI_UNDERFLOW_CNT_EN
        check("reset_uf_cnt", {16'h0, underflow_cnt}, 32'h0);
`endif
    endtask

    // Starts from IDLE, raises enable and checks every cycle of the listed frames against the raster rules.
    task automatic run(input int fill, input int uf_pos, input int drop_pos, input int rst_pos);
        logic [7:0]  rptr0;
        logic [23:0] words[$];
        logic [23:0] w;
        int          exp_idx, exp_pops, uf_seen, q, mq;
        bit          de, popped, exp_en;
        logic [23:0] dat;
        exp_idx  = 0;
        exp_pops = 0;
        uf_seen  = 0;
        rptr0    = rptr;
        words    = {};
        for (int i = 0; i < fill; i++) begin
            w = 24'($urandom) | 24'h1;
            mem[8'(rptr0 + 8'(i))] = w;
            words.push_back(w);
        end
        wptr        = rptr0 + 8'(fill);
        force_empty = 1'b0;
        enable      = 1'b1;
        for (int j = 0; j < fmode.size() * FT + LAT + 1; j++) begin
            @(negedge rd_clk);
            if (j == drop_pos) enable = 1'b0;
            force_empty = (j == uf_pos);
            #1;
            exp_en = (mode_of(j) == M_RUN) && pos_active(j) && (uf_pos < 0 || j < uf_pos);
            exp_pops += int'(exp_en);
            check("rd_en", {31'h0, fifo_rd_en}, {31'h0, exp_en});
            q = j - LAT - 1;
            if (q < 0 || mode_of(q) == M_IDLE) begin
                check("video", {4'h0, vid_hs, vid_vs, vid_de, frame_start, vid_data}, 32'h0);
            end else begin
                mq     = mode_of(q);
                de     = pos_active(q);
                popped = (mq == M_RUN) && de && (uf_pos < 0 || q < uf_pos);
                dat    = 24'h0;
                if (popped) begin
                    dat = (exp_idx < words.size()) ? words[exp_idx] : 24'hBADBAD;
                    exp_idx++;
                end
                check("video", {4'h0, vid_hs, vid_vs, vid_de, frame_start, vid_data},
                      {4'h0, pos_hs(q), pos_vs(q), de, popped && (q % FT == 0), dat});
            end
            uf_seen += int'(underflow);
            if (j == rst_pos) begin
                rd_rst = 1'b1;
                enable = 1'b0;
                @(negedge rd_clk);
                #1;
                check("rst_video", {4'h0, vid_hs, vid_vs, vid_de, frame_start, vid_data}, 32'h0);
                check("rst_ctl", {30'h0, fifo_rd_en, underflow}, 32'h0);
                rd_rst   = 1'b0;
                uf_total = 0;
                for (int k = 0; k < LAT + 4; k++) begin
                    @(negedge rd_clk);
                    #1;
                    check("stale", {7'h0, vid_de, vid_data}, 32'h0);
                end
`ifdef ZOOM_HDMI_UNDERFLOW_CNT_EN
                check("uf_cnt_after_rst", {16'h0, underflow_cnt}, 32'h0);
`endif
                return;
            end
        end
        check("pops", {24'h0, 8'(rptr - rptr0)}, {24'h0, 8'(exp_pops)});
        check("underflows", uf_seen, (uf_pos >= 0) ? 1 : 0);
        if (uf_pos >= 0) uf_total++;
`ifdef ZOOM_HDMI_UNDERFLOW_CNT_EN
        check("uf_cnt", {16'h0, underflow_cnt}, uf_total);
`endif
    endtask

    initial begin
        int upos;
        apply_reset();

        fmode = '{M_PRIME, M_RUN, M_RUN};
        run(64, -1, 2 * FT, -1);

        fmode = '{M_PRIME, M_PRIME, M_PRIME};
        run(int'($urandom_range(0, 4)), -1, 2 * FT, -1);

        for (int n = 0; n < 3; n++) begin
            upos  = FT + int'($urandom_range(0, 3)) * HT + int'($urandom_range(0, 7));
            fmode = '{M_PRIME, M_RUN, M_PRIME};
            run(64, upos, 2 * FT, -1);
        end

        fmode = '{M_PRIME, M_IDLE};
        run(64, -1, HT, -1);
        fmode = '{M_PRIME};
        run(64, -1, 0, -1);

        fmode = '{M_PRIME, M_RUN};
        run(64, -1, -1, FT + 2 * HT + 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
